data_sync_handshake: RTL

Multi-bit clock-domain-crossing synchroniser for the receive side of the bridge. It replaces per-bit flop synchronisation of a whole bus, which can tear multi-bit values, with an enable-qualified capture. The source domain presents a stable bus plus a single enable/toggle signal. Only that control bit passes through a configurable flop chain; its detected edge loads the bus into a destination register and emits a one-cycle valid pulse. It sits between the UART RX domain and the APB-side logic.

---
 rtl/data_sync_handshake_pkg.sv | 19 +
 rtl/data_sync_handshake_pulse.sv | 53 +++++
 rtl/data_sync_handshake.sv | 53 +++++
 3 files changed

// File: rtl/data_sync_handshake_pkg.sv
// Shared constants for the enable-qualified multi-bit CDC capture.
// Event encodings, legal synchroniser depths and the default bus width.
package data_sync_handshake_pkg;

   localparam int MODE_LEVEL      = 0;
   localparam int MODE_TOGGLE     = 1;
   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;
   localparam int BUS_WIDTH_DEF   = 16;

   function automatic bit stages_legal(input int n);
      return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
   endfunction

   function automatic bit mode_legal(input int m);
      return (m == MODE_LEVEL) || (m == MODE_TOGGLE);
   endfunction

endpackage

// File: rtl/data_sync_handshake_pulse.sv
// Single-bit control crossing: flop chain, previous-value register and
// edge detector producing a one-cycle event in the destination domain.
module sync_pulse_gen
   import data_sync_handshake_pkg::*;
#(
   parameter int NUM_STAGES = 2,
   parameter int MODE       = MODE_LEVEL
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_event
);

   if (!stages_legal(NUM_STAGES)) begin : g_bad_stages
      $error("sync_pulse_gen: NUM_STAGES must be within 2..4");
   end

   if (!mode_legal(MODE)) begin : g_bad_mode
      $error("sync_pulse_gen: MODE must be 0 (level) or 1 (toggle)");
   end

   logic [NUM_STAGES-1:0] r_sync_ff;
   logic                  r_prev_sync;
   logic                  w_synced;
   logic                  w_event;

   assign w_synced = r_sync_ff[NUM_STAGES-1];

   // Shift the raw control bit through the chain; remember last synced value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync_ff   <= '0;
         r_prev_sync <= 1'b0;
      end else begin
         r_sync_ff   <= {r_sync_ff[NUM_STAGES-2:0], i_async};
         r_prev_sync <= w_synced;
      end
   end

   // Level mode reacts to rising edges only; toggle mode to any change
   always_comb begin
      w_event = 1'b0;
      if (MODE == MODE_TOGGLE) begin
         w_event = w_synced ^ r_prev_sync;
      end else begin
         w_event = w_synced & ~r_prev_sync;
      end
   end

   assign o_event = w_event;

endmodule

// File: rtl/data_sync_handshake.sv
// Receive-side bus crossing: only bus_enable is synchronised; its event
// loads the held bus into the destination register with a valid strobe.
module data_sync_handshake
   import data_sync_handshake_pkg::*;
#(
   parameter int BUS_WIDTH  = BUS_WIDTH_DEF,
   parameter int NUM_STAGES = 2,
   parameter int MODE       = MODE_LEVEL
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BUS_WIDTH-1:0] unsync_bus,
   input  logic                 bus_enable,
   output logic [BUS_WIDTH-1:0] sync_bus,
   output logic                 enable_pulse
);

   logic                 w_event;
   logic [BUS_WIDTH-1:0] r_sync_bus;
   logic                 r_enable_pulse;

   sync_pulse_gen #(
      .NUM_STAGES (NUM_STAGES),
      .MODE       (MODE)
   ) u_pulse (
      .clk     (clk),
      .rst     (rst),
      .i_async (bus_enable),
      .o_event (w_event)
   );

   // Bus is only looked at on the event edge, so it may glitch elsewhere
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync_bus <= '0;
      end else if (w_event) begin
         r_sync_bus <= unsync_bus;
      end
   end

   // Strobe marks the cycle in which the new capture is first visible
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_enable_pulse <= 1'b0;
      end else begin
         r_enable_pulse <= w_event;
      end
   end

   assign sync_bus     = r_sync_bus;
   assign enable_pulse = r_enable_pulse;

endmodule
